// File: rtl/mmu_arbiter.sv
// rtl/mmu_arbiter.sv - two-requester round-robin job arbiter in front of an MMU sequencer
// Optional stall watchdog enabled by defining MMU_ARB_TIMEOUT_EN.
module mmu_arbiter (
    input  logic       clk,
    input  logic       rst,
    input  logic       req0,
    input  logic       req1,
    input  logic       in_valid0,
    input  logic       in_valid1,
    input  logic [7:0] in_data0,
    input  logic [7:0] in_data1,
    input  logic       out_ready0,
    input  logic       out_ready1,
    input  logic       mmu_done,
    input  logic [7:0] mmu_data,
    output logic       gnt0,
    output logic       gnt1,
    output logic       mem_load_en,
    output logic [7:0] mem_data,
    output logic       out_valid0,
    output logic       out_valid1,
    output logic [7:0] out_data,
    output logic       mmu_rd_next,
    output logic       mmu_clear,
    output logic       busy,
    output logic       timeout_err
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOAD    = 3'd1,
        COMPUTE = 3'd2,
        DRAIN   = 3'd3,
        RELEASE = 3'd4
    } state_t;

    state_t     state;
    logic       sel;
    logic       last_served;
    logic [2:0] byte_cnt;
    logic [1:0] beat_cnt;

    logic       req_sel;
    logic       valid_sel;
    logic       ready_sel;
    logic [7:0] data_sel;
    logic       active;
    logic       accept;
    logic       drain_valid;
    logic       handshake;
    logic       timeout_hit;

    assign req_sel   = sel ? req1 : req0;
    assign valid_sel = sel ? in_valid1 : in_valid0;
    assign ready_sel = sel ? out_ready1 : out_ready0;
    assign data_sel  = sel ? in_data1 : in_data0;

    assign active = (state == LOAD) || (state == COMPUTE) || (state == DRAIN);
    assign gnt0   = active & ~sel;
    assign gnt1   = active & sel;

    // A dropping request wins over a byte offered in the same cycle: nothing moves once abort is seen.
    assign accept      = (state == LOAD) & req_sel & valid_sel;
    assign mem_load_en = accept;
    assign mem_data    = accept ? data_sel : 8'h00;

    assign drain_valid = (state == DRAIN) & req_sel;
    assign out_valid0  = drain_valid & ~sel;
    assign out_valid1  = drain_valid & sel;
    assign out_data    = drain_valid ? mmu_data : 8'h00;
    assign handshake   = drain_valid & ready_sel;
    assign mmu_rd_next = handshake;

    assign mmu_clear = (state == RELEASE);
    assign busy      = (state != IDLE);

`ifdef MMU_ARB_TIMEOUT_EN
    logic [7:0] stall_cnt;
    logic       stalled;
    logic       timeout_q;

    assign stalled     = ((state == LOAD) & ~accept) | ((state == DRAIN) & ~handshake);
    assign timeout_hit = stalled & req_sel & (stall_cnt == 8'd254);
    assign timeout_err = timeout_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= 8'd0;
            timeout_q <= 1'b0;
        end else begin
            stall_cnt <= stalled ? stall_cnt + 8'd1 : 8'd0;
            timeout_q <= timeout_hit;
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign timeout_err = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            sel         <= 1'b0;
            last_served <= 1'b1;
            byte_cnt    <= 3'd0;
            beat_cnt    <= 2'd0;
        end else begin
            case (state)
                IDLE: begin
                    byte_cnt <= 3'd0;
                    beat_cnt <= 2'd0;
                    if (req0 | req1) begin
                        sel   <= (req0 & req1) ? ~last_served : req1;
                        state <= LOAD;
                    end
                end
                LOAD: begin
                    if (!req_sel || timeout_hit) begin
                        state <= RELEASE;
                    end else if (accept) begin
                        byte_cnt <= byte_cnt + 3'd1;
                        if (byte_cnt == 3'd7) begin
                            state <= COMPUTE;
                        end
                    end
                end
                COMPUTE: begin
                    if (!req_sel) begin
                        state <= RELEASE;
                    end else if (mmu_done) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (!req_sel || timeout_hit) begin
                        state <= RELEASE;
                    end else if (handshake) begin
                        beat_cnt <= beat_cnt + 2'd1;
                        if (beat_cnt == 2'd3) begin
                            state <= RELEASE;
                        end
                    end
                end
                RELEASE: begin
                    last_served <= sel;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
